// File: rtl/div.sv
// div: multi-cycle 32-bit radix-2 restoring divider for DIV / DIVU.
// The 64-bit result is {remainder, quotient}, written to HI/LO downstream.
// A divide takes 33 cycles after the request is accepted: 32 restoring
// steps followed by one sign-fix cycle. annul_i aborts an in-flight divide.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Working register: [64:33] partial remainder, [31:0] quotient/dividend.
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        quot_neg_q, quot_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] trial;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes, restoring trial subtraction and final sign fix.
  always_comb begin
    op1_abs  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    trial    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    quot_fix = quot_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem_fix  = rem_neg_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];
  end

  // Next-state and next-output logic for the divider FSM.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned; otherwise synthesis would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = 6'd0;
            // The extra low zero lets the first step shift the dividend MSB
            // into the partial remainder.
            work_d     = {32'd0, op1_abs, 1'b0};
            divisor_d  = op2_abs;
            quot_neg_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            rem_neg_d  = signed_div_i & opdata1_i[31];
          end
        end
      end

      DIV_BY_ZERO: begin
        // Architecturally unpredictable; this core returns zero.
        state_d  = DIV_END;
        result_d = 64'd0;
        ready_d  = 1'b1;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (trial[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {trial[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          cnt_d    = 6'd0;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end

      DIV_END: begin
        // annul_i is deliberately ignored: the result is already committed.
        if (!start_i) begin
          state_d  = DIV_FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that overrides start and annul.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values of the others, independent of statement order.
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= 6'd0;
      work_q     <= 65'd0;
      divisor_q  <= 32'd0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed and randomized checks of the div block against an
// arithmetic reference model (64-bit truncating division).
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on sign/zero-extended 64-bit values,
  // so the 0x80000000 / -1 case cannot overflow.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: request, measure latency, check hold (with scrambled
  // operands and annul), then release or reset and check the outputs clear.
  task automatic do_div(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input bit rst_in_end);
    logic [63:0] exp;
    int          exp_lat;
    int          k;
    exp     = ref_div(s, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    tick();  // edge N
    chk({tag, "_ready_at_N"}, {63'd0, ready_o}, 64'd0);
    k = 0;
    while (!ready_o && k < 40) begin
      signed_div_i = 1'($urandom);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      tick();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp);
    annul_i = 1'b1;
    repeat (2) tick();
    chk({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
    chk({tag, "_hold_result"}, result_o, exp);
    annul_i = 1'b0;
    start_i = 1'b0;
    if (rst_in_end) rst = 1'b1;
    tick();
    rst = 1'b0;
    chk({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    bit          seen;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) tick();
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // Directed cases with hand-derived results.
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    chk("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    do_div("divu_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    // Annul at iteration 10.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();  // edge N
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    chk("annul_result", result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    chk("annul_never_ready", {63'd0, seen}, 64'd0);
    do_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 1'b0);
    chk("model_divu_9_3", ref_div(1'b0, 32'd9, 32'd3), 64'h00000000_00000003);

    // Reset at iteration 20.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1234567;
    opdata2_i    = 32'd89;
    start_i      = 1'b1;
    tick();  // edge N
    repeat (20) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o) seen = 1'b1;
    end
    chk("midrst_never_ready", {63'd0, seen}, 64'd0);
    do_div("div_after_rst", 1'b1, 32'hFFFF0000, 32'd12345, 1'b0);

    // Reset while the result is being held.
    do_div("rst_in_end", 1'b0, 32'd77777, 32'd13, 1'b1);

    // Randomized operands, biased toward small divisors and zero.
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 3));
        1: b = $urandom & 32'h0000FFFF;
        2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), s, a, b, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
